// File: rtl/csr_exe_stage.sv
// CSR execute stage: reads the CSR file combinationally, computes the new CSR value,
// flags writes to read-only CSRs and holds one result behind a valid/ready handshake.
// Write enables toward csr_file and the GPR file are qualified with the output fire.
module csr_exe_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CSR_ADDR_WIDTH = 12,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [1:0]                op_i,
    input  logic                      use_imm_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
    input  logic [DATA_WIDTH-1:0]     pc_i,
    output logic [CSR_ADDR_WIDTH-1:0] csr_raddr_o,
    input  logic [DATA_WIDTH-1:0]     csr_rdata_i,
    input  logic                      flush_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
    output logic                      rd_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [DATA_WIDTH-1:0]     rd_wdata_o,
    output logic                      instret_incr_o,
    output logic                      illegal_o,
    output logic [DATA_WIDTH-1:0]     illegal_pc_o
);

    localparam logic [1:0] OpNone = 2'b00;
    localparam logic [1:0] OpRw   = 2'b01;
    localparam logic [1:0] OpRs   = 2'b10;
    localparam logic [1:0] OpRc   = 2'b11;

    logic                      valid_q;
    logic                      csr_we_q, rd_we_q, instret_q, illegal_q;
    logic [CSR_ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0]     wdata_q, old_q, pc_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;

    logic [DATA_WIDTH-1:0]     src, new_val;
    logic                      wr_req, illegal, rd_req, ready, accept, fire;

    // Decode the incoming instruction and compute the value to write back to the CSR.
    always_comb begin
        src     = use_imm_i ? {{(DATA_WIDTH-REG_ADDR_WIDTH){1'b0}}, rs1_addr_i} : rs1_data_i;
        new_val = csr_rdata_i;
        wr_req  = 1'b0;
        case (op_i)
            OpRw: begin
                new_val = src;
                wr_req  = 1'b1;
            end
            OpRs: begin
                new_val = csr_rdata_i | src;
                wr_req  = (rs1_addr_i != '0);
            end
            OpRc: begin
                new_val = csr_rdata_i & ~src;
                wr_req  = (rs1_addr_i != '0);
            end
            default: ;  // OpNone: plain retire, CSR value unchanged
        endcase
        // Top two address bits 2'b11 mark a read-only CSR.
        illegal = wr_req & (csr_addr_i[CSR_ADDR_WIDTH-1 -: 2] == 2'b11);
        rd_req  = (op_i != OpNone) & (rd_addr_i != '0) & ~illegal;
    end

    // Handshake: accept when empty or when the held entry leaves this cycle.
    always_comb begin
        ready  = ~valid_q | (ready_i & ~flush_i);
        accept = valid_i & ready;
        fire   = valid_q & ready_i & ~flush_i;
    end

    // Occupancy flag: a new accept wins over fire or flush of the held entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
        end else if (fire || flush_i) begin
            valid_q <= 1'b0;
        end
    end

    // Result register, captured on accept and otherwise held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csr_we_q  <= 1'b0;
            rd_we_q   <= 1'b0;
            instret_q <= 1'b0;
            illegal_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            old_q     <= '0;
            pc_q      <= '0;
            rd_addr_q <= '0;
        end else if (accept) begin
            csr_we_q  <= wr_req & ~illegal;
            rd_we_q   <= rd_req;
            instret_q <= ~illegal;
            illegal_q <= illegal;
            waddr_q   <= csr_addr_i;
            wdata_q   <= new_val;
            old_q     <= csr_rdata_i;
            pc_q      <= pc_i;
            rd_addr_q <= rd_addr_i;
        end
    end

    // Outputs: strobes qualified by fire, data zeroed while empty or in reset.
    always_comb begin
        ready_o        = rst_ni & ready;
        csr_raddr_o    = rst_ni ? csr_addr_i : '0;
        valid_o        = valid_q;
        csr_we_o       = csr_we_q & fire;
        rd_we_o        = rd_we_q & fire;
        instret_incr_o = instret_q & fire;
        illegal_o      = illegal_q & fire;
        csr_waddr_o    = valid_q ? waddr_q : '0;
        csr_wdata_o    = valid_q ? wdata_q : '0;
        rd_addr_o      = valid_q ? rd_addr_q : '0;
        rd_wdata_o     = valid_q ? old_q : '0;
        illegal_pc_o   = valid_q ? pc_q : '0;
    end

endmodule

// File: tb/tb_csr_exe_stage.sv
// Directed bench for csr_exe_stage: a vector table for single instructions plus
// hand-written sequences for stall, flush, reset and back-to-back bypass.
module tb_csr_exe_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, use_imm, flush, valid_o, ready_in;
    logic [1:0]  op;
    logic [4:0]  rs1_addr, rd_addr, rd_addr_o;
    logic [31:0] rs1_data, pc, csr_rdata, csr_wdata_o, rd_wdata_o, illegal_pc_o;
    logic [11:0] csr_addr, csr_raddr_o, csr_waddr_o;
    logic        csr_we_o, rd_we_o, instret_o, illegal_o;
    logic [31:0] rdata_base;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Minimal csr_file read port: same-cycle write bypass onto the read.
    assign csr_rdata = (csr_we_o && csr_waddr_o == csr_raddr_o) ? csr_wdata_o : rdata_base;

    csr_exe_stage dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .op_i           (op),
        .use_imm_i      (use_imm),
        .rs1_addr_i     (rs1_addr),
        .rs1_data_i     (rs1_data),
        .rd_addr_i      (rd_addr),
        .csr_addr_i     (csr_addr),
        .pc_i           (pc),
        .csr_raddr_o    (csr_raddr_o),
        .csr_rdata_i    (csr_rdata),
        .flush_i        (flush),
        .valid_o        (valid_o),
        .ready_i        (ready_in),
        .csr_we_o       (csr_we_o),
        .csr_waddr_o    (csr_waddr_o),
        .csr_wdata_o    (csr_wdata_o),
        .rd_we_o        (rd_we_o),
        .rd_addr_o      (rd_addr_o),
        .rd_wdata_o     (rd_wdata_o),
        .instret_incr_o (instret_o),
        .illegal_o      (illegal_o),
        .illegal_pc_o   (illegal_pc_o)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic        imm;
        logic [4:0]  rs1a;
        logic [31:0] rs1d;
        logic [4:0]  rd;
        logic [11:0] csr;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] wdata;
        logic        rd_we;
        logic [31:0] rd_wdata;
        logic        instret;
        logic        ill;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic [1:0] o, input logic im, input logic [4:0] ra,
                         input logic [31:0] rdv, input logic [4:0] rd,
                         input logic [11:0] ca, input logic [31:0] p);
        valid_i  = 1'b1;
        op       = o;
        use_imm  = im;
        rs1_addr = ra;
        rs1_data = rdv;
        rd_addr  = rd;
        csr_addr = ca;
        pc       = p;
    endtask

    task automatic all_zero(input string name);
        chk(name, 32'({valid_o, csr_we_o, rd_we_o, instret_o, illegal_o, ready_o}
                      | {26'b0, |{csr_waddr_o, csr_wdata_o, rd_addr_o, rd_wdata_o,
                                  illegal_pc_o, csr_raddr_o}}), 32'd0);
    endtask

    int writes;

    initial begin
        //          op     imm  rs1a   rs1d          rd     csr      pc           rdata
        //          we     wdata         rd_we  rd_wdata      instret ill
        vecs[0] = '{2'b01, 1'b0, 5'd1, 32'h12345678, 5'd5, 12'h340, 32'h00000010, 32'hDEADBEEF,
                    1'b1, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[1] = '{2'b11, 1'b1, 5'd3, 32'h0,        5'd1, 12'h300, 32'h00000014, 32'h0000000F,
                    1'b1, 32'h0000000C, 1'b1, 32'h0000000F, 1'b1, 1'b0};
        vecs[2] = '{2'b10, 1'b0, 5'd0, 32'h0,        5'd2, 12'h300, 32'h00000018, 32'h000000AA,
                    1'b0, 32'h000000AA, 1'b1, 32'h000000AA, 1'b1, 1'b0};
        vecs[3] = '{2'b01, 1'b0, 5'd4, 32'h00000007, 5'd3, 12'hC00, 32'h00000080, 32'h00000055,
                    1'b0, 32'h00000007, 1'b0, 32'h00000055, 1'b0, 1'b1};
        // Plain retire: only instret; CSR value passes through unchanged.
        vecs[4] = '{2'b00, 1'b0, 5'd9, 32'h0000FFFF, 5'd4, 12'h340, 32'h00000020, 32'h00000123,
                    1'b0, 32'h00000123, 1'b0, 32'h00000123, 1'b1, 1'b0};
        vecs[5] = '{2'b10, 1'b1, 5'h10, 32'hFFFFFFFF, 5'd0, 12'h305, 32'h00000024, 32'h00000001,
                    1'b1, 32'h00000011, 1'b0, 32'h00000001, 1'b1, 1'b0};
        vecs[6] = '{2'b11, 1'b0, 5'd6, 32'h000000F0, 5'd7, 12'hC01, 32'h00000028, 32'h000000FF,
                    1'b0, 32'h0000000F, 1'b0, 32'h000000FF, 1'b0, 1'b1};
        // Read-only CSR with rs1=x0 is a pure read, not illegal.
        vecs[7] = '{2'b10, 1'b0, 5'd0, 32'h0,        5'd7, 12'hC00, 32'h0000002C, 32'h00001234,
                    1'b0, 32'h00001234, 1'b1, 32'h00001234, 1'b1, 1'b0};

        rst_n = 1'b0; valid_i = 1'b0; flush = 1'b0; ready_in = 1'b1; rdata_base = '0;
        drive(2'b01, 1'b0, 5'd1, 32'h1, 5'd1, 12'h123, 32'h4);
        valid_i = 1'b0;
        #12;
        all_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", 32'(ready_o), 32'd1);
        chk("post_reset_valid", 32'(valid_o), 32'd0);

        // Table vectors, one at a time with wb always ready.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].imm, vecs[i].rs1a, vecs[i].rs1d, vecs[i].rd,
                  vecs[i].csr, vecs[i].pc);
            rdata_base = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_raddr", i), 32'(csr_raddr_o), 32'(vecs[i].csr));
            @(negedge clk);
            valid_i = 1'b0;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'd1);
            chk($sformatf("v%0d_csr_we", i), 32'(csr_we_o), 32'(vecs[i].we));
            chk($sformatf("v%0d_waddr", i), 32'(csr_waddr_o), 32'(vecs[i].csr));
            chk($sformatf("v%0d_wdata", i), csr_wdata_o, vecs[i].wdata);
            chk($sformatf("v%0d_rd_we", i), 32'(rd_we_o), 32'(vecs[i].rd_we));
            chk($sformatf("v%0d_rd_addr", i), 32'(rd_addr_o), 32'(vecs[i].rd));
            chk($sformatf("v%0d_rd_wdata", i), rd_wdata_o, vecs[i].rd_wdata);
            chk($sformatf("v%0d_instret", i), 32'(instret_o), 32'(vecs[i].instret));
            chk($sformatf("v%0d_illegal", i), 32'(illegal_o), 32'(vecs[i].ill));
            chk($sformatf("v%0d_ill_pc", i), illegal_pc_o, vecs[i].pc);
        end
        @(negedge clk);
        #1;
        chk("drain_valid", 32'(valid_o), 32'd0);
        chk("drain_wdata_zero", csr_wdata_o, 32'd0);

        // Stall for 3 cycles, then release: exactly one write.
        ready_in = 1'b0;
        drive(2'b01, 1'b0, 5'd2, 32'h000000A5, 5'd8, 12'h341, 32'h40);
        rdata_base = 32'h77;
        @(negedge clk);
        valid_i = 1'b0;
        writes = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d_ready", c), 32'(ready_o), 32'd0);
            chk($sformatf("hold%0d_we", c), 32'(csr_we_o | rd_we_o | instret_o), 32'd0);
            chk($sformatf("hold%0d_wdata", c), csr_wdata_o, 32'h000000A5);
            chk($sformatf("hold%0d_valid", c), 32'(valid_o), 32'd1);
            @(negedge clk);
        end
        ready_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (csr_we_o) writes++;
            @(negedge clk);
        end
        chk("hold_release_writes", 32'(writes), 32'd1);

        // Flush a held entry while a new instruction is offered.
        ready_in = 1'b0;
        drive(2'b01, 1'b0, 5'd2, 32'h11, 5'd9, 12'h342, 32'h50);
        @(negedge clk);
        drive(2'b01, 1'b0, 5'd3, 32'h22, 5'd10, 12'h343, 32'h54);
        ready_in = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_no_write", 32'(csr_we_o | rd_we_o | instret_o), 32'd0);
        chk("flush_ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("flush_valid_cleared", 32'(valid_o), 32'd0);

        // Reset while holding: everything drops immediately, nothing written after.
        ready_in = 1'b0;
        @(negedge clk);
        drive(2'b01, 1'b0, 5'd2, 32'h33, 5'd11, 12'h344, 32'h60);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("rst_hold_valid", 32'(valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        all_zero("rst_mid_hold");
        @(negedge clk);
        rst_n = 1'b1;
        ready_in = 1'b1;
        #1;
        chk("rst_after_valid", 32'(valid_o | csr_we_o), 32'd0);

        // Back-to-back RAW on 0x340: second read sees first write via bypass.
        rdata_base = 32'h0;
        @(negedge clk);
        drive(2'b01, 1'b0, 5'd1, 32'h1, 5'd12, 12'h340, 32'h70);
        @(negedge clk);
        drive(2'b10, 1'b0, 5'd2, 32'h2, 5'd13, 12'h340, 32'h74);
        #1;
        chk("b2b_first_we", 32'(csr_we_o), 32'd1);
        chk("b2b_ready", 32'(ready_o), 32'd1);
        chk("b2b_bypass_read", csr_rdata, 32'h1);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("b2b_second_valid", 32'(valid_o), 32'd1);
        chk("b2b_second_wdata", csr_wdata_o, 32'h3);
        chk("b2b_second_old", rd_wdata_o, 32'h1);
        chk("b2b_second_we", 32'(csr_we_o), 32'd1);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
